// File: rtl/rpsc_pkg.sv
// Shared types for the RPSC power-on sequencer: FSM states, fault causes,
// stage indices and small mask helpers.
package rpsc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAMP     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_RUN      = 3'd3,
    ST_SHUTDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_PERM    = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_FB_LOST = 2'd3
  } cause_t;

  localparam logic [1:0] STG_FAN   = 2'd0;
  localparam logic [1:0] STG_CA    = 2'd1;
  localparam logic [1:0] STG_G1    = 2'd2;
  localparam logic [1:0] STG_ANODE = 2'd3;

  // Bits strictly below stage s.
  function automatic logic [3:0] mask_below(input logic [1:0] s);
    logic [4:0] m;
    m = (5'd1 << s) - 5'd1;
    return m[3:0];
  endfunction

  // Bits 0..s inclusive.
  function automatic logic [3:0] mask_upto(input logic [1:0] s);
    logic [4:0] m;
    m = (5'd2 << s) - 5'd1;
    return m[3:0];
  endfunction

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rpsc_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, one chain per bit.
module rpsc_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/rpsc_on_sequencer.sv
// Ordered FAN -> CA -> G1 -> Anode power-on/off sequencer with permit and
// feedback supervision; any trip drops every command at once.
module rpsc_on_sequencer
  import rpsc_pkg::*;
#(
  parameter int CONFIRM_TO = 1000,
  parameter int SETTLE_CYC = 500,
  parameter int OFF_CYC    = 200,
  parameter int CNT_W      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_fault,
  input  logic [3:0] perm,
  input  logic [3:0] on_fb,
  output logic [3:0] cmd,
  output logic       running,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_stage,
  output logic [1:0] fault_cause,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_TO - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_CYC - 1);

  logic [3:0]       perm_s, fb_s;
  state_t           state_reg, state_next;
  logic [1:0]       stage_reg, stage_next;
  logic [CNT_W-1:0] timer_reg;
  logic             timer_clr;
  logic [3:0]       cmd_reg, cmd_next;
  logic [1:0]       fstage_reg, fstage_next;
  cause_t           fcause_reg, fcause_next;
  logic [3:0]       confirmed, perm_miss, fb_miss;
  logic             monitor_on;

  rpsc_sync2 #(.W(4)) u_sync_perm (.clk(clk), .reset(reset), .d(perm),  .q(perm_s));
  rpsc_sync2 #(.W(4)) u_sync_fb   (.clk(clk), .reset(reset), .d(on_fb), .q(fb_s));

  assign monitor_on = (state_reg == ST_RAMP) || (state_reg == ST_SETTLE) || (state_reg == ST_RUN);
  assign perm_miss  = cmd_reg & ~perm_s;
  assign fb_miss    = confirmed & ~fb_s;

  always_comb begin
    state_next  = state_reg;
    stage_next  = stage_reg;
    fstage_next = fstage_reg;
    fcause_next = fcause_reg;
    case (state_reg)
      ST_RAMP:   confirmed = mask_below(stage_reg);
      ST_SETTLE: confirmed = mask_upto(stage_reg);
      ST_RUN:    confirmed = 4'hF;
      default:   confirmed = 4'h0;
    endcase

    // Supervision outranks stop and the normal ramp progression.
    if (monitor_on && (perm_miss != 4'h0)) begin
      state_next  = ST_FAULT;
      fcause_next = CAUSE_PERM;
      fstage_next = lowest_set(perm_miss);
    end else if (monitor_on && (fb_miss != 4'h0)) begin
      state_next  = ST_FAULT;
      fcause_next = CAUSE_FB_LOST;
      fstage_next = lowest_set(fb_miss);
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !stop) begin
            stage_next = STG_FAN;
            if (perm_s[STG_FAN]) begin
              state_next = ST_RAMP;
            end else begin
              state_next  = ST_FAULT;
              fcause_next = CAUSE_PERM;
              fstage_next = STG_FAN;
            end
          end
        end
        ST_RAMP: begin
          if (stop) begin
            state_next = ST_SHUTDOWN;
          end else if (fb_s[stage_reg]) begin
            state_next = ST_SETTLE;
          end else if (timer_reg == CONFIRM_LAST) begin
            state_next  = ST_FAULT;
            fcause_next = CAUSE_TIMEOUT;
            fstage_next = stage_reg;
          end
        end
        ST_SETTLE: begin
          if (stop) begin
            state_next = ST_SHUTDOWN;
          end else if (timer_reg == SETTLE_LAST) begin
            if (stage_reg == STG_ANODE) begin
              state_next = ST_RUN;
            end else if (perm_s[stage_reg + 2'd1]) begin
              state_next = ST_RAMP;
              stage_next = stage_reg + 2'd1;
            end else begin
              state_next  = ST_FAULT;
              fcause_next = CAUSE_PERM;
              fstage_next = stage_reg + 2'd1;
            end
          end
        end
        ST_RUN: begin
          if (stop) state_next = ST_SHUTDOWN;
        end
        ST_SHUTDOWN: begin
          if (timer_reg == OFF_LAST) begin
            if (stage_reg == STG_FAN) state_next = ST_IDLE;
            else                      stage_next = stage_reg - 2'd1;
          end
        end
        ST_FAULT: begin
          if (clear_fault && (fb_s == 4'h0)) begin
            state_next  = ST_IDLE;
            fstage_next = 2'd0;
            fcause_next = CAUSE_NONE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    timer_clr = (state_next != state_reg) || (stage_next != stage_reg);

    // Commands are derived from the next state so they land on the same edge.
    case (state_next)
      ST_RAMP, ST_SETTLE: cmd_next = mask_upto(stage_next);
      ST_RUN:             cmd_next = 4'hF;
      ST_SHUTDOWN:        cmd_next = mask_below(stage_next);
      default:            cmd_next = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      stage_reg  <= STG_FAN;
      timer_reg  <= '0;
      cmd_reg    <= 4'h0;
      fstage_reg <= 2'd0;
      fcause_reg <= CAUSE_NONE;
    end else begin
      state_reg  <= state_next;
      stage_reg  <= stage_next;
      cmd_reg    <= cmd_next;
      fstage_reg <= fstage_next;
      fcause_reg <= fcause_next;
      if (timer_clr)              timer_reg <= '0;
      else if (timer_reg != '1)   timer_reg <= timer_reg + 1'b1;
    end
  end

  assign cmd         = cmd_reg;
  assign running     = (state_reg == ST_RUN);
  assign busy        = (state_reg == ST_RAMP) || (state_reg == ST_SETTLE) || (state_reg == ST_SHUTDOWN);
  assign fault       = (state_reg == ST_FAULT);
  assign fault_stage = fstage_reg;
  assign fault_cause = fcause_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_rpsc_on_sequencer.sv
// Bench for rpsc_on_sequencer: a feedback plant follows cmd with per-stage
// delays and expected waveforms come from timeline arithmetic.
module tb_rpsc_on_sequencer;
  import rpsc_pkg::*;

  localparam int CONFIRM_TO = 8;
  localparam int SETTLE_CYC = 4;
  localparam int OFF_CYC    = 3;
  localparam int SYNC_LAT   = 3;  // drive tick -> two sync edges -> FSM edge

  logic       clk = 1'b0;
  logic       reset, start, stop, clear_fault;
  logic [3:0] perm, on_fb, cmd;
  logic       running, busy, fault;
  logic [1:0] fault_stage, fault_cause;
  logic [2:0] state;

  rpsc_on_sequencer #(
    .CONFIRM_TO(CONFIRM_TO), .SETTLE_CYC(SETTLE_CYC), .OFF_CYC(OFF_CYC), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear_fault(clear_fault),
    .perm(perm), .on_fb(on_fb), .cmd(cmd), .running(running), .busy(busy),
    .fault(fault), .fault_stage(fault_stage), .fault_cause(fault_cause), .state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tk = 0;
  int dly[4];
  int on_cnt[4];
  int rise[4];
  int tmo, end_t, run_t;
  logic [3:0] fb_en, fb_force;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h (tick %0d)", tag, got, exp, tk);
    end
  endtask

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  // One clock: sample point just after the edge, then plant update.
  task automatic tick();
    logic [3:0] plant;
    @(posedge clk);
    #1;
    tk++;
    for (int i = 0; i < 4; i++) begin
      if (cmd[i]) on_cnt[i]++;
      else        on_cnt[i] = 0;
      plant[i] = cmd[i] && (on_cnt[i] > dly[i]);
    end
    on_fb = (plant & fb_en) | fb_force;
  endtask

  task automatic rand_dly();
    for (int i = 0; i < 4; i++) dly[i] = $urandom_range(0, 5);
  endtask

  // Plan the ramp timeline for a start pulse issued at this tick.
  task automatic begin_seq();
    int r;
    start = 1'b1;
    r = tk + 1;
    tmo = 4;
    for (int i = 0; i < 4; i++) begin
      rise[i] = r;
      if (tmo == 4 && (!fb_en[i] || dly[i] + SYNC_LAT > CONFIRM_TO)) tmo = i;
      r += dly[i] + SYNC_LAT + SETTLE_CYC;
    end
    run_t = r;
    end_t = (tmo < 4) ? rise[tmo] + CONFIRM_TO : run_t;
  endtask

  task automatic check_until(input int t_last);
    logic [3:0] m;
    logic ex_run, ex_busy, ex_fault;
    while (tk < t_last) begin
      tick();
      start = 1'b0;
      m = 4'h0;
      if (tmo < 4 && tk >= end_t) begin
        ex_run = 1'b0; ex_busy = 1'b0; ex_fault = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) if (i <= tmo && rise[i] <= tk) m[i] = 1'b1;
        ex_run   = (tmo == 4) && (tk >= run_t);
        ex_busy  = (tk >= rise[0]) && !ex_run;
        ex_fault = 1'b0;
      end
      chk("ramp_cmd", 32'(cmd), 32'(m));
      chk("ramp_running", 32'(running), 32'(ex_run));
      chk("ramp_busy", 32'(busy), 32'(ex_busy));
      chk("ramp_fault", 32'(fault), 32'(ex_fault));
    end
  endtask

  task automatic shutdown();
    int p, n;
    logic [31:0] ex;
    p = tk;
    stop = 1'b1;
    while (tk < p + 4 * OFF_CYC + 2) begin
      tick();
      stop = 1'b0;
      n = (tk - p - 1) / OFF_CYC;
      if (n <= 3) begin
        ex = (32'd1 << (3 - n)) - 32'd1;
        chk("off_cmd", 32'(cmd), ex);
        chk("off_busy", 32'(busy), 32'd1);
      end else begin
        chk("off_cmd", 32'(cmd), 32'd0);
        chk("off_busy", 32'(busy), 32'd0);
        chk("off_idle", 32'(state), 32'(ST_IDLE));
      end
    end
  endtask

  task automatic trip(input logic [3:0] m, input bit is_perm, input int cause);
    if (is_perm) begin
      perm = perm & ~m;
    end else begin
      fb_en = ~m;
      on_fb = on_fb & ~m;
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k < 3) begin
        chk("trip_hold_cmd", 32'(cmd), 32'hF);
        chk("trip_hold_fault", 32'(fault), 32'd0);
      end else begin
        chk("trip_cmd", 32'(cmd), 32'd0);
        chk("trip_fault", 32'(fault), 32'd1);
        chk("trip_cause", 32'(fault_cause), 32'(cause));
        chk("trip_stage", 32'(fault_stage), 32'(lowest(m)));
      end
    end
  endtask

  task automatic recover();
    perm = 4'hF;
    fb_en = 4'hF;
    fb_force = 4'h0;
    repeat (3) tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clr_state", 32'(state), 32'(ST_IDLE));
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_cause", 32'(fault_cause), 32'd0);
    chk("clr_stage", 32'(fault_stage), 32'd0);
    tick();
  endtask

  task automatic run_to_run();
    rand_dly();
    fb_en = 4'hF;
    begin_seq();
    check_until(end_t + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [3:0] m;
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear_fault = 1'b0;
    perm = 4'hF; on_fb = 4'h0; fb_en = 4'hF; fb_force = 4'h0;
    for (int i = 0; i < 4; i++) begin dly[i] = 2; on_cnt[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fstage", 32'(fault_stage), 32'd0);
    chk("rst_fcause", 32'(fault_cause), 32'd0);
    reset = 1'b1;
    repeat (3) tick();

    // Full sequence with feedback two cycles behind cmd.
    begin_seq();
    check_until(end_t + 1);
    chk("full_cmd", 32'(cmd), 32'hF);
    shutdown();

    // Random feedback delays, one iteration pinned at the confirm boundary.
    for (int it = 0; it < 4; it++) begin
      rand_dly();
      if (it == 0) dly[$urandom_range(0, 3)] = 5;
      begin_seq();
      check_until(end_t + 1 + $urandom_range(0, 4));
      shutdown();
    end

    // CA feedback never arrives.
    for (int i = 0; i < 4; i++) dly[i] = 2;
    fb_en = 4'b1101;
    begin_seq();
    check_until(end_t + 1);
    chk("tmo_cause", 32'(fault_cause), 32'd2);
    chk("tmo_stage", 32'(fault_stage), 32'd1);
    recover();

    // Feedback one cycle too slow at a random stage.
    rand_dly();
    k = $urandom_range(0, 3);
    dly[k] = 6;
    begin_seq();
    check_until(end_t + 1);
    chk("tmo_rand_cause", 32'(fault_cause), 32'd2);
    chk("tmo_rand_stage", 32'(fault_stage), 32'(k));
    recover();

    // Permit loss in RUN: G1 and Anode together, then a random set.
    run_to_run();
    trip(4'b1100, 1'b1, 1);
    recover();
    run_to_run();
    m = 4'($urandom_range(1, 15));
    trip(m, 1'b1, 1);
    recover();

    // Feedback loss in RUN; clear is refused while any feedback is on.
    run_to_run();
    trip(4'b0001, 1'b0, 3);
    fb_force = 4'b0010;
    repeat (3) tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    tick();
    chk("clr_refused_fault", 32'(fault), 32'd1);
    chk("clr_refused_cause", 32'(fault_cause), 32'd3);
    chk("clr_refused_stage", 32'(fault_stage), 32'd0);
    recover();
    run_to_run();
    m = 4'($urandom_range(1, 15));
    trip(m, 1'b0, 3);
    recover();

    // Start without FAN permit.
    perm = 4'hE;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("noperm_fault", 32'(fault), 32'd1);
    chk("noperm_cause", 32'(fault_cause), 32'd1);
    chk("noperm_stage", 32'(fault_stage), 32'd0);
    chk("noperm_cmd", 32'(cmd), 32'd0);
    tick();
    chk("noperm_cmd_hold", 32'(cmd), 32'd0);
    recover();

    // start and stop together in IDLE.
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_state", 32'(state), 32'(ST_IDLE));
    chk("startstop_cmd", 32'(cmd), 32'd0);
    tick();
    chk("startstop_busy", 32'(busy), 32'd0);

    // Asynchronous reset while settling G1.
    for (int i = 0; i < 4; i++) dly[i] = 1;
    fb_en = 4'hF;
    begin_seq();
    check_until(rise[2] + dly[2] + SYNC_LAT + 1);
    chk("rstmid_settle", 32'(state), 32'(ST_SETTLE));
    chk("rstmid_cmd_before", 32'(cmd), 32'h7);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_cmd", 32'(cmd), 32'd0);
    chk("rstmid_state", 32'(state), 32'(ST_IDLE));
    #2 reset = 1'b1;
    tick();
    chk("rstmid_after_state", 32'(state), 32'(ST_IDLE));
    chk("rstmid_after_cmd", 32'(cmd), 32'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
